// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory responder slice.
// Provides the default array geometry, the arbitration starvation limit,
// the responder FSM state encoding and an address range-check helper.
package mips32_pkg;

  localparam int MEM_DEPTH        = 1024;  // 32-bit words, matches core Mem[0:1023]
  localparam int MEM_AW           = 10;    // clog2(MEM_DEPTH)
  localparam int MEM_STARVE_LIMIT = 4;     // IF-denied cycles before IF wins once
  localparam int WORD_W           = 32;    // request/response data width
  localparam int ADDR_W           = 32;    // request address width

  typedef enum logic {
    ST_INIT = 1'b0,  // zero-filling the array, requests ignored
    ST_RUN  = 1'b1   // serving IF and DM requests
  } mem_state_e;

  // A 32-bit word address is usable only when it falls inside the array.
  // A plain magnitude compare also covers any nonzero upper bits.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return addr < ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/mips32_mem_arbiter.sv
// Two-port arbiter for the memory responder.
// DM has fixed priority (it belongs to the older instruction). A counter of
// consecutive IF-denied cycles forces one IF grant once it reaches STARVE_LIMIT.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en                   arbitration enabled (responder in RUN)
//   if_valid, dm_valid   request valids of the two ports
//   grant_if, grant_dm   combinational one-hot-or-zero grants
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic if_valid,
  input  logic dm_valid,
  output logic grant_if,
  output logic grant_dm
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    grant_if = en && if_valid && (!dm_valid || starved);
    grant_dm = en && dm_valid && !grant_if;
  end

  // Counts cycles in which IF asked and lost; any IF win or IF idle cycle
  // clears it. Held at zero while arbitration is disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      starve_cnt <= '0;
    end else if (!if_valid || grant_if) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory-side responder for the MIPS32 core.
// One single-port word array serves the IF read port and the DM load/store
// port. After reset the array is zero-filled (INIT), then requests are
// arbitrated one per cycle (RUN). Responses appear the cycle after acceptance;
// out-of-range addresses skip the array access and answer with err = 1.
// Handshake: a request is accepted on a rising edge where valid && ready;
// ready is combinational from both valids and the arbiter grant. Responses are
// single-cycle strobes with no backpressure.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req_valid/ready/addr          IF read request
//   if_rsp_valid/data/err            IF read response
//   dm_req_valid/ready/we/addr/wdata DM load/store request
//   dm_rsp_valid/data/err            DM response (data 0 for stores)
//   init_done                        high once the clear sequence is complete
module mips32_mem_responder
  import mips32_pkg::*;
#(
  parameter int DEPTH        = MEM_DEPTH,
  parameter int AW           = MEM_AW,
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic        dm_req_we,
  input  logic [31:0] dm_req_addr,
  input  logic [31:0] dm_req_wdata,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_data,
  output logic        dm_rsp_err,
  output logic        init_done
);

  mem_state_e    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          run;

  logic          grant_if, grant_dm;
  logic          if_acc, dm_acc;
  logic          if_ok, dm_ok;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_q;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_idx, acc_idx;
  logic [31:0]   wr_data;

  logic          if_rsp_valid_q, if_rsp_err_q;
  logic          dm_rsp_valid_q, dm_rsp_err_q, dm_rsp_load_q;

  assign run = (state_q == ST_RUN);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------- arbitration ----------------
  mips32_mem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (run),
    .if_valid(if_req_valid),
    .dm_valid(dm_req_valid),
    .grant_if(grant_if),
    .grant_dm(grant_dm)
  );

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  // A handshake coinciding with reset is discarded: no write, no response.
  assign if_acc = grant_if && !rst;
  assign dm_acc = grant_dm && !rst;

  assign if_ok = addr_in_range(if_req_addr, DEPTH);
  assign dm_ok = addr_in_range(dm_req_addr, DEPTH);

  // ---------------- single array port ----------------
  // Grants are exclusive, so one address mux feeds the only access.
  assign acc_idx = grant_if ? if_req_addr[AW-1:0] : dm_req_addr[AW-1:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = acc_idx;
    wr_data = dm_req_wdata;
    if (!rst) begin
      if (!run) begin
        wr_en   = 1'b1;
        wr_idx  = clr_cnt_q;
        wr_data = '0;
      end else if (dm_acc && dm_req_we && dm_ok) begin
        wr_en = 1'b1;
      end
    end
  end

  assign rd_en = (if_acc && if_ok) || (dm_acc && !dm_req_we && dm_ok);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_q <= mem[acc_idx];
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      dm_rsp_valid_q <= 1'b0;
      dm_rsp_err_q   <= 1'b0;
      dm_rsp_load_q  <= 1'b0;
    end else begin
      if_rsp_valid_q <= if_acc;
      if_rsp_err_q   <= if_acc && !if_ok;
      dm_rsp_valid_q <= dm_acc;
      dm_rsp_err_q   <= dm_acc && !dm_ok;
      dm_rsp_load_q  <= dm_acc && !dm_req_we && dm_ok;
    end
  end

  // Data is forced to zero for errors and store acknowledges, so the shared
  // read register only shows through on a good read response.
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign if_rsp_data  = (if_rsp_valid_q && !if_rsp_err_q) ? rd_q : '0;
  assign dm_rsp_valid = dm_rsp_valid_q;
  assign dm_rsp_err   = dm_rsp_err_q;
  assign dm_rsp_data  = dm_rsp_load_q ? rd_q : '0;
  assign init_done    = run;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench for mips32_mem_responder.
module tb_mips32_mem_responder;

  localparam int DEPTH  = 1024;
  localparam int STARVE = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic        dm_rsp_valid, dm_rsp_err;
  logic [31:0] dm_rsp_data;
  logic        init_done;

  always #5 clk = ~clk;

  mips32_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr (if_req_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data (if_rsp_data),
    .if_rsp_err  (if_rsp_err),
    .dm_req_valid(dm_req_valid),
    .dm_req_ready(dm_req_ready),
    .dm_req_we   (dm_req_we),
    .dm_req_addr (dm_req_addr),
    .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_data (dm_rsp_data),
    .dm_rsp_err  (dm_rsp_err),
    .init_done   (init_done)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  int          ref_k;       // non-reset edges since the last reset
  int          ref_starve;  // consecutive IF-denied cycles
  logic [32:0] exp_if_q[$]; // {err, data}
  logic [32:0] exp_dm_q[$];

  // values sampled at the falling edge of the last step
  logic        s_if_ready, s_dm_ready, s_if_v, s_dm_v, s_if_e, s_dm_e, s_init;
  logic [31:0] s_if_d, s_dm_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    ref_k      = 0;
    ref_starve = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_if_q.delete();
    exp_dm_q.delete();
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; drives, samples at the falling edge,
  // compares against the model, then advances the model over the next edge.
  task automatic step(input logic r, input logic ifv, input logic [31:0] ifa,
                      input logic dmv, input logic we, input logic [31:0] dma,
                      input logic [31:0] wd);
    logic        run, gi, gd, ok, ev;
    logic [32:0] e;
    rst = r; if_req_valid = ifv; if_req_addr = ifa;
    dm_req_valid = dmv; dm_req_we = we; dm_req_addr = dma; dm_req_wdata = wd;
    @(negedge clk);
    s_if_ready = if_req_ready; s_dm_ready = dm_req_ready;
    s_if_v = if_rsp_valid; s_if_d = if_rsp_data; s_if_e = if_rsp_err;
    s_dm_v = dm_rsp_valid; s_dm_d = dm_rsp_data; s_dm_e = dm_rsp_err;
    s_init = init_done;

    run = (ref_k >= DEPTH);
    gi  = run && ifv && (!dmv || ref_starve == STARVE);
    gd  = run && dmv && !gi;
    check("init_done", s_init, run);
    if (!r) begin
      check("if_req_ready", s_if_ready, gi);
      check("dm_req_ready", s_dm_ready, gd);
    end
    ev = (exp_if_q.size() > 0);
    e  = ev ? exp_if_q.pop_front() : 33'h0;
    check("if_rsp_valid", s_if_v, ev);
    check("if_rsp_data", s_if_d, e[31:0]);
    check("if_rsp_err", s_if_e, e[32]);
    ev = (exp_dm_q.size() > 0);
    e  = ev ? exp_dm_q.pop_front() : 33'h0;
    check("dm_rsp_valid", s_dm_v, ev);
    check("dm_rsp_data", s_dm_d, e[31:0]);
    check("dm_rsp_err", s_dm_e, e[32]);

    if (r) begin
      model_clear();
    end else begin
      if (gi) begin
        ok = (ifa < 32'(DEPTH));
        exp_if_q.push_back({!ok, ok ? ref_mem[ifa[9:0]] : 32'h0});
      end
      if (gd) begin
        ok = (dma < 32'(DEPTH));
        if (we) begin
          if (ok) ref_mem[dma[9:0]] = wd;
          exp_dm_q.push_back({!ok, 32'h0});
        end else begin
          exp_dm_q.push_back({!ok, ok ? ref_mem[dma[9:0]] : 32'h0});
        end
      end
      if (run && ifv && !gi) ref_starve = (ref_starve < STARVE) ? ref_starve + 1 : STARVE;
      else                   ref_starve = 0;
      if (ref_k < DEPTH) ref_k++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Steps through INIT with stray requests, counting cycles with init_done low.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      step(1'b0, 1'(($urandom_range(0, 3)) == 0), 32'($urandom_range(0, 15)),
           1'(($urandom_range(0, 3)) == 0), 1'b0, 32'($urandom_range(0, 15)), 32'h0);
      if (s_init) break;
      n++;
    end
    check(name, n, 32'd1024);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        dmv;
    logic        we;
    logic [31:0] dma;
    logic [31:0] wd;
    logic        e_ifr;
    logic        e_dmr;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_ife;
    logic        e_dmv;
    logic [31:0] e_dmd;
    logic        e_dme;
  } vec_t;

  vec_t vecs[9];

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          wait_cur, wait_max;
    logic        oor;
    logic [31:0] a1, a2;

    // expected responses are the ones visible during that vector's cycle
    vecs[0] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'd5,    32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'd5,    32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'd1024, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'd0,    32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
    vecs[4] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 32'd5,         1'b1, 1'b0, 32'd5,    32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
    vecs[7] = '{1'b1, 32'd5,         1'b0, 1'b0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[8] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,    32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,         1'b0};

    rst = 1'b1; if_req_valid = 1'b0; if_req_addr = '0;
    dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_addr = '0; dm_req_wdata = '0;
    @(posedge clk);
    #1;
    model_clear();

    // reset state, then the full clear sequence
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_init("init_cycles");

    // cleared array reads zero at both ends and a few random words
    step(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 32'd1023, 32'h0);
    step(1'b0, 1'b1, 32'd1023, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 32'($urandom_range(0, 1023)), 1'b1, 1'b0, 32'($urandom_range(0, 1023)), 32'h0);
    idle();
    idle();

    // store/load forwarding, range errors, simple arbitration
    for (int v = 0; v < 9; v++) begin
      step(1'b0, vecs[v].ifv, vecs[v].ifa, vecs[v].dmv, vecs[v].we, vecs[v].dma, vecs[v].wd);
      check($sformatf("vec%0d_if_ready", v), s_if_ready, vecs[v].e_ifr);
      check($sformatf("vec%0d_dm_ready", v), s_dm_ready, vecs[v].e_dmr);
      check($sformatf("vec%0d_if_rsp_valid", v), s_if_v, vecs[v].e_ifv);
      check($sformatf("vec%0d_if_rsp_data", v), s_if_d, vecs[v].e_ifd);
      check($sformatf("vec%0d_if_rsp_err", v), s_if_e, vecs[v].e_ife);
      check($sformatf("vec%0d_dm_rsp_valid", v), s_dm_v, vecs[v].e_dmv);
      check($sformatf("vec%0d_dm_rsp_data", v), s_dm_d, vecs[v].e_dmd);
      check($sformatf("vec%0d_dm_rsp_err", v), s_dm_e, vecs[v].e_dme);
    end

    // both ports busy every cycle: IF wins on every fifth cycle
    idle();
    wait_cur = 0;
    wait_max = 0;
    for (int c = 0; c < 15; c++) begin
      step(1'b0, 1'b1, 32'(c), 1'b1, 1'b0, 32'(c + 16), 32'h0);
      check($sformatf("starve_grant_%0d", c), s_if_ready, 32'((c % 5) == 4));
      wait_cur++;
      if (s_if_ready) begin
        if (wait_cur > wait_max) wait_max = wait_cur;
        wait_cur = 0;
      end
    end
    check("if_max_wait", wait_max, 32'(STARVE + 1));
    idle();

    // streaming IF reads of preloaded words
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'(i), 32'(100 + i));
    idle();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) step(1'b0, 1'b1, 32'(i), 1'b0, 1'b0, 32'h0, 32'h0);
      else       idle();
      if (i > 0) begin
        check($sformatf("stream_valid_%0d", i - 1), s_if_v, 32'd1);
        check($sformatf("stream_data_%0d", i - 1), s_if_d, 32'(100 + i - 1));
      end
    end

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      oor = ($urandom_range(0, 9) == 0);
      a1  = oor ? (($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'(1024 + $urandom_range(0, 7)))
                : 32'($urandom_range(0, 15));
      oor = ($urandom_range(0, 9) == 0);
      a2  = oor ? $urandom() | 32'h0000_0400 : 32'($urandom_range(0, 15));
      step(1'b0, 1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), a2, $urandom());
    end
    idle();

    // reset during an accepted store, then reset mid-INIT
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd9, 32'h55);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'd9, 32'd7);
    idle();
    check("rst_store_no_rsp", s_dm_v, 32'd0);
    for (int c = 0; c < 499; c++) idle();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_init("reinit_cycles");
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd9, 32'h0);
    idle();
    check("word9_valid", s_dm_v, 32'd1);
    check("word9_data", s_dm_d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
